// File: rtl/spi_pkg.sv
// Shared types for the SPI command sequencer.
// Word width default and sequencer FSM states.
package spi_pkg;
  localparam int DATA_W = 12;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT
  } seq_state_t;
endpackage

// File: rtl/spi_seq_fifo.sv
// Synchronous FIFO buffering producer words ahead of the SPI launch.
// Full/empty come from the occupancy count; pointers wrap modulo DEPTH.
module spi_seq_fifo #(
  parameter int DW    = 12,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          wr;
  logic          rd;

  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);
  assign wr    = push && !full;
  assign rd    = pop && !empty;
  assign dout  = mem[rp];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr) begin
        mem[wp] <= din;
        wp      <= wp + 1'b1;
      end
      if (rd) rp <= rp + 1'b1;
      unique case (1'b1)
        wr && !rd: level <= level + 1'b1;
        rd && !wr: level <= level - 1'b1;
        default:   level <= level;
      endcase
    end
  end
endmodule

// File: rtl/spi_cmd_sequencer.sv
// Feeds queued words to the SPI top one at a time, returns each result
// through a single-entry slot, and aborts transfers whose done never comes.
module spi_cmd_sequencer #(
  parameter int DATA_W  = spi_pkg::DATA_W,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     s_valid,
  input  logic [DATA_W-1:0]        s_data,
  output logic                     s_ready,
  output logic                     spi_new_data,
  output logic [DATA_W-1:0]        spi_din,
  input  logic                     spi_done,
  input  logic [DATA_W-1:0]        spi_dout,
  output logic                     r_valid,
  output logic [DATA_W-1:0]        r_data,
  input  logic                     r_ready,
  output logic                     busy,
  output logic                     timeout_err,
  output logic [$clog2(DEPTH):0]   level
);
  import spi_pkg::*;

  localparam int WW = $clog2(TIMEOUT);

  seq_state_t        state;
  logic [WW-1:0]     wd;
  logic [DATA_W-1:0] head;
  logic              full;
  logic              empty;
  logic              pop;

  // A pending result blocks the next launch: that is the back-pressure path.
  assign pop     = (state == IDLE) && !empty && !r_valid;
  assign s_ready = !full;
  assign busy    = (state != IDLE) || !empty;

  spi_seq_fifo #(
    .DW    (DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (s_valid),
    .pop   (pop),
    .din   (s_data),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      wd           <= '0;
      spi_new_data <= 1'b0;
      spi_din      <= '0;
      r_valid      <= 1'b0;
      r_data       <= '0;
      timeout_err  <= 1'b0;
    end else begin
      spi_new_data <= 1'b0;
      timeout_err  <= 1'b0;
      if (r_valid && r_ready) r_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pop) begin
            spi_din      <= head;
            wd           <= '0;
            spi_new_data <= 1'b1;
            state        <= LAUNCH;
          end
        end
        LAUNCH: begin
          wd    <= wd + 1'b1;
          state <= WAIT;
        end
        WAIT: begin
          if (spi_done) begin
            r_data  <= spi_dout;
            r_valid <= 1'b1;
            state   <= IDLE;
          end else if (wd == WW'(TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
